// File: rtl/hubris_isa_pkg.sv
// hubris_isa_pkg: shared opcodes, invalid-instruction encoding and halt-state type
package hubris_isa_pkg;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  // The all-zero word doubles as the halt request: it never issues and starts the drain.
  localparam logic [31:0] INVALID_INST = 32'h0000_0000;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage instruction in, issue/stall/halt out
interface hazard_scoreboard_if #(parameter int W = 32);
  logic         id_valid;
  logic [W-1:0] id_inst;
  logic         issue;
  logic         stall_id_if_pl;
  logic         stall_pc_increment;
  logic         halt;
  modport master (output id_valid, id_inst, input issue, stall_id_if_pl, stall_pc_increment, halt);
  modport slave  (input id_valid, id_inst, output issue, stall_id_if_pl, stall_pc_increment, halt);
endinterface

// File: rtl/inst_reg_usage.sv
// inst_reg_usage: opcode decode into register read/write usage and control class
module inst_reg_usage
  import hubris_isa_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       rd_written,
  output logic       is_load,
  output logic       is_branch,
  output logic       is_jump
);
  assign is_load    = opcode == OPCODE_LOAD;
  assign is_branch  = opcode == OPCODE_BRANCH;
  assign is_jump    = opcode == OPCODE_JAL || opcode == OPCODE_JALR;
  assign rs2_used   = opcode == OPCODE_OP || is_branch || opcode == OPCODE_STORE;
  assign rs1_used   = rs2_used || opcode == OPCODE_OP_IMM || is_load || opcode == OPCODE_JALR;
  assign rd_written = opcode == OPCODE_OP || opcode == OPCODE_OP_IMM || opcode == OPCODE_LUI ||
                      opcode == OPCODE_AUIPC || is_jump || is_load;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID issue control with per-register countdown scoreboard and halt drain
// HAZARD_FORWARD_EN: EX/MEM bypass present, only the load-use bubble stalls on data
module hazard_scoreboard
  import hubris_isa_pkg::*;
#(
  parameter int INST_WIDTH_IN_BIT = 32,
  parameter int NUM_REGS          = 32,
  parameter int ALU_LAT           = 2,
  parameter int LOAD_LAT          = 3,
  parameter int BRANCH_STALL      = 1,
  parameter int JUMP_STALL        = 2
) (
  input logic                clk,
  input logic                reset_n,
  hazard_scoreboard_if.slave bus
);
  localparam int MAXL = ALU_LAT > LOAD_LAT ? ALU_LAT : LOAD_LAT;
  localparam int CW   = $clog2((MAXL > 1 ? MAXL : 1) + 1);
  localparam int MAXC = BRANCH_STALL > JUMP_STALL ? BRANCH_STALL : JUMP_STALL;
  localparam int TW   = $clog2((MAXC > 1 ? MAXC : 1) + 1);
  localparam int RW   = $clog2(NUM_REGS);
  logic [CW-1:0] cnt [NUM_REGS];
  logic [TW-1:0] ctrl_cnt;
  halt_state_t   state, state_d;
  logic [RW-1:0] rs1, rs2, rd;
  logic rs1_used, rs2_used, rd_written, dec_load, is_branch, is_jump;
  logic busy1, busy2, hazard, invalid, all_idle, stall, rd_rec;
  assign rs1    = bus.id_inst[15 +: RW];
  assign rs2    = bus.id_inst[20 +: RW];
  assign rd     = bus.id_inst[7 +: RW];
  assign rd_rec = bus.issue && rd_written && rd != '0;
  inst_reg_usage u_dec (
    .opcode    (bus.id_inst[6:0]),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .rd_written(rd_written),
    .is_load   (dec_load),
    .is_branch (is_branch),
    .is_jump   (is_jump)
  );
`ifdef HAZARD_FORWARD_EN
  // Producer kind only matters when ALU results can be bypassed.
  logic is_load [NUM_REGS];
  assign busy1 = is_load[rs1] && cnt[rs1] != '0 && cnt[rs1] >= CW'(LOAD_LAT);
  assign busy2 = is_load[rs2] && cnt[rs2] != '0 && cnt[rs2] >= CW'(LOAD_LAT);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int r = 0; r < NUM_REGS; r++) is_load[r] <= 1'b0;
    else
      for (int r = 0; r < NUM_REGS; r++) is_load[r] <= rd_rec && rd == RW'(r) ? dec_load : is_load[r];
`else
  assign busy1 = cnt[rs1] != '0;
  assign busy2 = cnt[rs2] != '0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      ctrl_cnt <= '0;
      state    <= RUN;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= rd_rec && rd == RW'(r) ? (dec_load ? CW'(LOAD_LAT) : CW'(ALU_LAT)) :
                  cnt[r] != '0 ? cnt[r] - 1'b1 : cnt[r];
      ctrl_cnt <= bus.issue && (is_branch || is_jump) ? (is_branch ? TW'(BRANCH_STALL) : TW'(JUMP_STALL)) :
                  ctrl_cnt != '0 ? ctrl_cnt - 1'b1 : ctrl_cnt;
      state    <= state_d;
    end
  always_comb begin
    all_idle = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) all_idle = all_idle && cnt[r] == '0;
    hazard  = bus.id_valid && ((rs1_used && rs1 != '0 && busy1) || (rs2_used && rs2 != '0 && busy2));
    invalid = bus.id_valid && bus.id_inst == INST_WIDTH_IN_BIT'(INVALID_INST);
    stall   = state != RUN || ctrl_cnt != '0 || hazard || invalid;
    state_d = state == RUN   ? (invalid && ctrl_cnt == '0 ? DRAIN : RUN) :
              state == DRAIN ? (all_idle && ctrl_cnt == '0 ? HALTED : DRAIN) : HALTED;
  end
  assign bus.issue              = bus.id_valid && !stall;
  assign bus.stall_id_if_pl     = stall;
  assign bus.stall_pc_increment = stall;
  assign bus.halt               = state == HALTED;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of RAW, control, halt-drain and reset behaviour
module tb_hazard_scoreboard;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int total = 0;
  int pc_bad = 0;
  hazard_scoreboard_if bus ();
  hazard_scoreboard dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] add_i(int rd, int a, int b);
    return {7'b0, b[4:0], a[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] sub_i(int rd, int a, int b);
    return {7'b0100000, b[4:0], a[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] lw_i(int rd, int a);
    return {12'd0, a[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] beq_i(int a, int b);
    return {7'b0, b[4:0], a[4:0], 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] jal_i(int rd);
    return {20'd0, rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] jalr_i(int rd, int a);
    return {12'd0, a[4:0], 3'b000, rd[4:0], 7'b1100111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.id_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Present inst until it issues; count stalled cycles, leave at the edge it issued on.
  task automatic run(input string tag, input logic [31:0] inst, input int exp);
    int n = 0;
    bus.id_valid = 1'b1;
    bus.id_inst  = inst;
    #1;
    while (!bus.issue && n < 20) begin
      if (bus.stall_pc_increment !== bus.stall_id_if_pl) pc_bad++;
      n++;
      tick();
    end
    if (bus.stall_pc_increment !== bus.stall_id_if_pl) pc_bad++;
    tick();
    bus.id_valid = 1'b0;
    chk(tag, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int issued = 0;
    int cycles = 0;
    bus.id_valid = 1'b0;
    bus.id_inst  = '0;
    #3;
    chk("rst_stall", bus.stall_id_if_pl, 0);
    chk("rst_issue", bus.issue, 0);
    chk("rst_halt", bus.halt, 0);
    #9;
    reset_n = 1'b1;
    tick();
    run("add_x5", add_i(5, 1, 2), 0);
    run("sub_raw", sub_i(6, 5, 3), FWD ? 0 : 2);
    run("lw_x7", lw_i(7, 1), 0);
    run("load_use", add_i(8, 7, 7), FWD ? 1 : 3);
    idle(4);
    run("add_x0", add_i(0, 1, 2), 0);
    run("read_x0", add_i(9, 0, 0), 0);
    idle(4);
    run("beq", beq_i(1, 2), 0);
    run("after_beq", add_i(10, 1, 2), 1);
    run("jal", jal_i(1), 0);
    run("after_jal", add_i(11, 2, 3), 2);
    run("lw_x1", lw_i(1, 2), 0);
    run("jalr_wait", jalr_i(0, 1), FWD ? 1 : 3);
    run("after_jalr", add_i(12, 2, 3), 2);
    run("beq2", beq_i(2, 3), 0);
    #1;
    chk("bubble_ctrl_stall", bus.stall_id_if_pl, 1);
    chk("bubble_no_issue", bus.issue, 0);
    tick();
    chk("bubble_ctrl_clear", bus.stall_id_if_pl, 0);
    idle(4);
    run("lw_x9", lw_i(9, 1), 0);
    bus.id_valid = 1'b1;
    bus.id_inst  = 32'h0;
    #1;
    chk("zero_stall", bus.stall_id_if_pl, 1);
    chk("zero_no_issue", bus.issue, 0);
    chk("zero_halt0", bus.halt, 0);
    tick();
    chk("drain_e1_halt", bus.halt, 0);
    tick();
    tick();
    chk("drain_e3_halt", bus.halt, 0);
    tick();
    chk("halted_e4", bus.halt, 1);
    bus.id_inst = add_i(5, 1, 2);
    #1;
    chk("halted_no_issue", bus.issue, 0);
    chk("halted_stall", bus.stall_id_if_pl, 1);
    tick();
    chk("halt_sticky", bus.halt, 1);
    bus.id_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_halted_halt", bus.halt, 0);
    #2;
    reset_n = 1'b1;
    tick();
    run("lw_x9_b", lw_i(9, 1), 0);
    bus.id_valid = 1'b1;
    bus.id_inst  = 32'h0;
    tick();
    bus.id_valid = 1'b0;
    #1;
    chk("drain_bubble_stall", bus.stall_id_if_pl, 1);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_drain_halt", bus.halt, 0);
    chk("rst_drain_stall", bus.stall_id_if_pl, 0);
    chk("rst_drain_issue", bus.issue, 0);
    #1;
    reset_n = 1'b1;
    run("post_rst_add", add_i(5, 1, 2), 0);
    run("post_rst_x9", add_i(10, 9, 9), 0);
    idle(4);
    while (issued < 6 && cycles < 200) begin
      bus.id_valid = 1'($urandom_range(0, 1));
      bus.id_inst  = add_i(13, 13, 14);
      #1;
      if (bus.stall_pc_increment !== bus.stall_id_if_pl) pc_bad++;
      if (bus.issue) issued++;
      tick();
      cycles++;
    end
    bus.id_valid = 1'b0;
    chk("chain_issues", issued, 6);
    chk("chain_min_cycles", cycles >= (FWD ? 6 : 16), 1);
    chk("stall_pc_eq", pc_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule
